// File: rtl/det_pkg.sv
// Shared definitions for the serial 1101 detector and its word sequencer.
// Contents:
//   - sequencer state encodings (3-bit) and the enum built from them
//   - the detector's S0..S3 state encodings
//   - the pattern the detector searches for
//   - det_released(): whether a sequencer state lets the detector out of reset
package det_pkg;

  // Sequencer state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARM   = ST_ARM,
    SHIFT = ST_SHIFT,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } seq_state_e;

  // Detector FSM encodings (S0 = nothing matched yet).
  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;
  localparam logic [1:0] DET_S3 = 2'd3;

  // Bit pattern recognised by the detector, first-received bit in the MSB.
  localparam logic [3:0] DET_PATTERN = 4'b1101;

  // The detector runs only while a word is being fed or drained.
  function automatic logic det_released(input seq_state_e s);
    case (s)
      ARM, SHIFT, DRAIN: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/det_bit_serializer.sv
// Parallel-to-serial converter for one word, MSB first.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   load         : capture data and arm the bit counter with WORD_W
//   shift        : move the next bit into the MSB and count one bit issued
//   data         : word to serialise
//   msb          : bit currently at the head of the register
//   last         : every bit of the word has been issued
module det_bit_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              msb,
  output logic              last
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  // bitcnt counts bits of the word not yet taken out of the MSB.
  logic [CW-1:0]     bitcnt_q, bitcnt_d;

  // Next-state for the shift register and bit counter; load wins over shift.
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (load) begin
      shreg_d  = data;
      bitcnt_d = CW'(WORD_W);
    end else if (shift) begin
      shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
      bitcnt_d = bitcnt_q - CW'(1);
    end else begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign msb  = shreg_q[WORD_W-1];
  assign last = (bitcnt_q == CW'(0));

endmodule

// File: rtl/detector_sequencer_chk.sv
// Property checker for detector_sequencer, instantiated by the top.
// Ports:
//   clock, reset : sampling clock, asynchronous active-low reset
//   state        : sequencer state register
//   in_ready     : input handshake ready
//   det_reset_n  : detector reset output
module detector_sequencer_chk
  import det_pkg::*;
(
  input logic       clock,
  input logic       reset,
  input seq_state_e state,
  input logic       in_ready,
  input logic       det_reset_n
);

  // Words are accepted only from IDLE.
  a_ready_idle : assert property (@(posedge clock) disable iff (!reset)
    in_ready == (state == IDLE));

  // The detector is held in reset whenever no word is in flight.
  a_det_held : assert property (@(posedge clock) disable iff (!reset)
    ((state == IDLE) || (state == DONE)) |-> (det_reset_n == 1'b0));

endmodule

// File: rtl/detector_sequencer.sv
// Feeds parallel words to a serial 1101 pattern detector one bit per clock,
// MSB first, and returns the number of detector hits per word.
// Ports:
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    : word handshake, in_data sampled on the accept edge
//   abort                : synchronous drop of the word in flight
//   det_x, det_reset_n   : registered drive of the detector's x and reset
//   det_y                : detector match flag (Moore, one cycle behind x)
//   out_valid/out_ready  : hit-count handshake, out_count held while valid
//   busy                 : a word is in flight or its count is pending
module detector_sequencer
  import det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              abort,
  output logic              det_x,
  output logic              det_reset_n,
  input  logic              det_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  seq_state_e       state_q, state_d;
  logic             det_x_q, det_x_d;
  logic             det_reset_n_q, det_reset_n_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic load_s;
  logic shift_s;
  logic ser_msb_s;
  logic ser_last_s;

  det_bit_serializer #(.WORD_W(WORD_W)) u_ser (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .shift (shift_s),
    .data  (in_data),
    .msb   (ser_msb_s),
    .last  (ser_last_s)
  );

  // Control FSM next state; abort beats every other request outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = ARM;
        else          state_d = IDLE;
      end
      ARM: begin
        if (abort) state_d = IDLE;
        else       state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)           state_d = IDLE;
        else if (ser_last_s) state_d = DRAIN;
        else                 state_d = SHIFT;
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else       state_d = DONE;
      end
      DONE: begin
        if (abort || out_ready) state_d = IDLE;
        else                    state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer control and the registered detector drive. Both detector
  // signals come from state_d so they change only on a flop edge; the bit
  // leaves the serializer on the same edge that presents it on det_x.
  always_comb begin
    load_s        = (state_q == IDLE) && in_valid;
    shift_s       = (state_d == SHIFT);
    det_reset_n_d = det_released(state_d);
    out_valid_d   = (state_d == DONE);
    if (state_d == SHIFT) det_x_d = ser_msb_s;
    else                  det_x_d = 1'b0;
  end

  // Hit counter: cleared on accept or abort, saturating increment on det_y
  // while the word's bits are passing through the detector.
  always_comb begin
    count_d = count_q;
    if (load_s) begin
      count_d = '0;
    end else if (abort && (state_q != IDLE)) begin
      count_d = '0;
    end else if (((state_q == SHIFT) || (state_q == DRAIN)) && det_y &&
                 (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      det_x_q       <= 1'b0;
      det_reset_n_q <= 1'b0;
      out_valid_q   <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      det_x_q       <= det_x_d;
      det_reset_n_q <= det_reset_n_d;
      out_valid_q   <= out_valid_d;
      count_q       <= count_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign det_x       = det_x_q;
  assign det_reset_n = det_reset_n_q;
  assign out_valid   = out_valid_q;
  assign out_count   = count_q;

  detector_sequencer_chk u_chk (
    .clock       (clock),
    .reset       (reset),
    .state       (state_q),
    .in_ready    (in_ready),
    .det_reset_n (det_reset_n_q)
  );

endmodule

// File: tb/tb_detector_sequencer.sv
// Bench for detector_sequencer: two instances (4-bit and 1-bit hit counts)
// share stimulus, each driving its own behavioural 1101 detector. A timeline
// model tracks edges since the accept edge and predicts every output.
module tb_detector_sequencer;
  import det_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int CW2 = 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic          in_ready, det_x, det_reset_n, det_y, out_valid, busy;
  logic [CW-1:0] out_count;
  logic           in_ready_b, det_x_b, det_reset_n_b, det_y_b, out_valid_b, busy_b;
  logic [CW2-1:0] out_count_b;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  detector_sequencer #(.WORD_W(W), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .det_x(det_x), .det_reset_n(det_reset_n),
    .det_y(det_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .busy(busy)
  );

  detector_sequencer #(.WORD_W(W), .CNT_W(CW2)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .abort(abort), .det_x(det_x_b), .det_reset_n(det_reset_n_b),
    .det_y(det_y_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_count(out_count_b), .busy(busy_b)
  );

  // Detector stand-ins: y is high when the last four bits since reset are 1101.
  logic [3:0] hist_a = 4'b0;
  logic [3:0] hist_b = 4'b0;
  always @(posedge clock or negedge det_reset_n)
    if (!det_reset_n) hist_a <= 4'b0;
    else              hist_a <= {hist_a[2:0], det_x};
  always @(posedge clock or negedge det_reset_n_b)
    if (!det_reset_n_b) hist_b <= 4'b0;
    else                hist_b <= {hist_b[2:0], det_x_b};
  assign det_y   = (hist_a == DET_PATTERN);
  assign det_y_b = (hist_b == DET_PATTERN);

  // Reference hit count: overlapping 4-bit windows, saturated to cntw bits.
  function automatic int ref_hits(input logic [W-1:0] w, input int cntw);
    int n;
    n = 0;
    for (int i = 0; i <= W - 4; i++)
      if (w[i +: 4] == DET_PATTERN) n++;
    if (n > (1 << cntw) - 1) n = (1 << cntw) - 1;
    return n;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_e = edges elapsed since the accept edge of the word in flight.
  bit           m_active = 1'b0;
  int           m_e = 0;
  logic [W-1:0] m_word = '0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_e      <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_e      <= 0;
        m_word   <= in_data;
      end
    end else if (abort) begin
      m_active <= 1'b0;
    end else if (m_e >= W + 2) begin
      if (out_ready) m_active <= 1'b0;
    end else begin
      m_e <= m_e + 1;
    end
  end

  function automatic logic exp_dx();
    if (m_active && m_e >= 1 && m_e <= W) return m_word[W - m_e];
    return 1'b0;
  endfunction
  function automatic logic exp_rn();
    return m_active && (m_e <= W + 1);
  endfunction
  function automatic logic exp_ov();
    return m_active && (m_e >= W + 2);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("busy", busy, m_active);
    chk("in_ready", in_ready, !m_active);
    chk("det_x", det_x, exp_dx());
    chk("det_reset_n", det_reset_n, exp_rn());
    chk("out_valid", out_valid, exp_ov());
    chk("out_valid_b", out_valid_b, exp_ov());
    chk("det_x_b", det_x_b, exp_dx());
    if (exp_ov()) begin
      chk("out_count", out_count, ref_hits(m_word, CW));
      chk("out_count_b", out_count_b, ref_hits(m_word, CW2));
    end
    if (!reset) chk("out_count_reset", out_count, 0);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Send one word, check latency, optionally the serial bits, and the count.
  task automatic run_word(input logic [W-1:0] w, input int exp_hits, input bit serial);
    int n;
    bit seen;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    chk("ready_before_word", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      n++;
      if (serial && n <= W) chk("serial_bit", det_x, w[W - n]);
      if (out_valid) seen = 1'b1;
    end
    chk("out_valid_seen", seen, 1);
    chk("latency_edges", n, W + 2);
    chk("word_hits", out_count, exp_hits);
    chk("word_hits_sat1", out_count_b, (exp_hits > 1) ? 1 : exp_hits);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_after_take", in_ready, 1);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) step();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_det_reset_n", det_reset_n, 0);
    chk("reset_det_x", det_x, 0);
    chk("reset_out_valid", out_valid, 0);
    reset = 1'b1;
    step();

    // Pin the reference model with hand-computed counts.
    chk("ref_d2", ref_hits(8'b1101_1010, CW), 2);
    chk("ref_0d", ref_hits(8'b0000_1101, CW), 1);
    chk("ref_ff", ref_hits(8'hFF, CW), 0);
    chk("ref_00", ref_hits(8'h00, CW), 0);
    chk("ref_sat1", ref_hits(8'b1101_1010, CW2), 1);

    // Overlapping match, serial order, latency.
    run_word(8'b1101_1010, 2, 1'b1);
    // Match on the final bit, seen only in DRAIN.
    run_word(8'b0000_1101, 1, 1'b1);
    // No hits, and none across the word boundary.
    run_word(8'hFF, 0, 1'b0);
    run_word(8'h00, 0, 1'b0);

    // Back-pressure in DONE with a producer waiting.
    in_valid  = 1'b1;
    in_data   = 8'b1101_1010;
    out_ready = 1'b0;
    step();
    in_data = 8'h0D;
    for (int k = 0; k < 30 && !out_valid; k++) step();
    chk("bp_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_count", out_count, 2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle", in_ready, 1);
    chk("bp_drop_valid", out_valid, 0);
    step();
    chk("bp_accept", busy, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 30 && !out_valid; k++) step();
    chk("bp_second_count", out_count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Abort during the third SHIFT cycle.
    in_valid = 1'b1;
    in_data  = 8'b1101_1010;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", in_ready, 1);
    chk("abort_no_valid", out_valid, 0);
    chk("abort_det_rst", det_reset_n, 0);
    run_word(8'b1101_1010, 2, 1'b0);

    // Asynchronous reset in the middle of SHIFT.
    in_valid = 1'b1;
    in_data  = 8'hB6;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_det_rst", det_reset_n, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    reset = 1'b1;
    step();
    run_word(8'b1101_1010, 2, 1'b1);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(499, 0) == 0) begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end else begin
        in_valid  = ($urandom_range(3, 0) != 0);
        in_data   = W'($urandom);
        out_ready = ($urandom_range(2, 0) == 0);
        abort     = ($urandom_range(29, 0) == 0);
        step();
      end
    end
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    chk("final_idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
